// File: rtl/ctrl_pkg.sv
// Shared types and constants for the LEGv8 control pipeline: per-stage control
// bundles, their bubble values, the zero register and forwarding-select encodings.
package ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '{alusrc: 1'b0, aluop: 2'b00};
  localparam mem_ctrl_t MEM_BUBBLE = '{memread: 1'b0, memwrite: 1'b0, branch: 1'b0};
  localparam wb_ctrl_t  WB_BUBBLE  = '{regwrite: 1'b0, memtoreg: 1'b0};

  // The zero register never carries a live value, so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic             mem_rw,
                                         input logic [REG_W-1:0] mem_rd,
                                         input logic             wb_rw,
                                         input logic [REG_W-1:0] wb_rd,
                                         input logic [REG_W-1:0] ra);
    if (mem_rw && (mem_rd != XZR) && (mem_rd == ra))
      return FWD_MEM;
    else if (wb_rw && (wb_rd != XZR) && (wb_rd == ra))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard logic: load-use stall, taken-branch flush and the
// EX-stage operand forwarding selects.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] ex_ra1_i,
  input  logic [REG_W-1:0] ex_ra2_i,
  input  logic [REG_W-1:0] id_ra1_i,
  input  logic [REG_W-1:0] id_ra2_i,
  input  logic             mem_branch_i,
  input  logic             mem_zero_i,
  input  logic             mem_regwrite_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             wb_regwrite_i,
  input  logic [REG_W-1:0] wb_rd_i,
  output logic             flush_o,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o
);

  logic load_use;

  assign load_use = ex_memread_i && (ex_rd_i != XZR) &&
                    ((ex_rd_i == id_ra1_i) || (ex_rd_i == id_ra2_i));

  // A taken branch squashes the stalled consumer anyway, so flush wins.
  assign flush_o        = mem_branch_i & mem_zero_i;
  assign stall_o        = load_use & ~flush_o;
  assign pc_write_o     = ~stall_o;
  assign ifid_write_o   = ~stall_o;
  assign ifid_flush_o   = flush_o;
  assign idex_bubble_o  = stall_o | flush_o;
  assign exmem_bubble_o = flush_o;

  assign forward_a_o = fwd_sel(mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i, ex_ra1_i);
  assign forward_b_o = fwd_sel(mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i, ex_ra2_i);

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control and register-number pipeline registers of
// the 5-stage LEGv8 pipeline, with bubble insertion driven by the hazard unit.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic [REG_W-1:0] id_ra1,
  input  logic [REG_W-1:0] id_ra2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_rd,
  output logic             pcsrc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush
);

  // ID/EX
  ex_ctrl_t         idex_ex_q,  idex_ex_d;
  mem_ctrl_t        idex_mem_q, idex_mem_d;
  wb_ctrl_t         idex_wb_q,  idex_wb_d;
  logic [REG_W-1:0] idex_ra1_q, idex_ra1_d;
  logic [REG_W-1:0] idex_ra2_q, idex_ra2_d;
  logic [REG_W-1:0] idex_rd_q,  idex_rd_d;
  // EX/MEM
  mem_ctrl_t        exmem_mem_q, exmem_mem_d;
  wb_ctrl_t         exmem_wb_q,  exmem_wb_d;
  logic [REG_W-1:0] exmem_rd_q,  exmem_rd_d;
  // MEM/WB
  wb_ctrl_t         memwb_wb_q, memwb_wb_d;
  logic [REG_W-1:0] memwb_rd_q, memwb_rd_d;

  logic flush, stall, idex_bubble, exmem_bubble;

  hazard_unit u_hazard (
    .ex_memread_i   (idex_mem_q.memread),
    .ex_rd_i        (idex_rd_q),
    .ex_ra1_i       (idex_ra1_q),
    .ex_ra2_i       (idex_ra2_q),
    .id_ra1_i       (id_ra1),
    .id_ra2_i       (id_ra2),
    .mem_branch_i   (exmem_mem_q.branch),
    .mem_zero_i     (mem_zero),
    .mem_regwrite_i (exmem_wb_q.regwrite),
    .mem_rd_i       (exmem_rd_q),
    .wb_regwrite_i  (memwb_wb_q.regwrite),
    .wb_rd_i        (memwb_rd_q),
    .flush_o        (flush),
    .stall_o        (stall),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_bubble_o (exmem_bubble),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b)
  );

  // Bubbles are selected by mux against constants so X on id_* never leaks.
  always_comb begin
    idex_ex_d  = EX_BUBBLE;
    idex_mem_d = MEM_BUBBLE;
    idex_wb_d  = WB_BUBBLE;
    idex_ra1_d = XZR;
    idex_ra2_d = XZR;
    idex_rd_d  = XZR;
    if (!idex_bubble) begin
      idex_ex_d  = '{alusrc: id_alusrc, aluop: id_aluop};
      idex_mem_d = '{memread: id_memread, memwrite: id_memwrite, branch: id_branch};
      idex_wb_d  = '{regwrite: id_regwrite, memtoreg: id_memtoreg};
      idex_ra1_d = id_ra1;
      idex_ra2_d = id_ra2;
      idex_rd_d  = id_rd;
    end
  end

  always_comb begin
    exmem_mem_d = MEM_BUBBLE;
    exmem_wb_d  = WB_BUBBLE;
    exmem_rd_d  = XZR;
    if (!exmem_bubble) begin
      exmem_mem_d = idex_mem_q;
      exmem_wb_d  = idex_wb_q;
      exmem_rd_d  = idex_rd_q;
    end
  end

  // The branch itself still retires into MEM/WB; its WB control is already zero.
  assign memwb_wb_d = exmem_wb_q;
  assign memwb_rd_d = exmem_rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ex_q   <= EX_BUBBLE;
      idex_mem_q  <= MEM_BUBBLE;
      idex_wb_q   <= WB_BUBBLE;
      idex_ra1_q  <= XZR;
      idex_ra2_q  <= XZR;
      idex_rd_q   <= XZR;
      exmem_mem_q <= MEM_BUBBLE;
      exmem_wb_q  <= WB_BUBBLE;
      exmem_rd_q  <= XZR;
      memwb_wb_q  <= WB_BUBBLE;
      memwb_rd_q  <= XZR;
    end else begin
      idex_ex_q   <= idex_ex_d;
      idex_mem_q  <= idex_mem_d;
      idex_wb_q   <= idex_wb_d;
      idex_ra1_q  <= idex_ra1_d;
      idex_ra2_q  <= idex_ra2_d;
      idex_rd_q   <= idex_rd_d;
      exmem_mem_q <= exmem_mem_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_rd_q  <= exmem_rd_d;
      memwb_wb_q  <= memwb_wb_d;
      memwb_rd_q  <= memwb_rd_d;
    end
  end

  assign ex_alusrc    = idex_ex_q.alusrc;
  assign ex_aluop     = idex_ex_q.aluop;
  assign mem_memread  = exmem_mem_q.memread;
  assign mem_memwrite = exmem_mem_q.memwrite;
  assign mem_branch   = exmem_mem_q.branch;
  assign wb_regwrite  = memwb_wb_q.regwrite;
  assign wb_memtoreg  = memwb_wb_q.memtoreg;
  assign wb_rd        = memwb_rd_q;
  assign pcsrc        = flush;

  // stall is consumed only inside the hazard unit's derived outputs.
  logic unused_stall;
  assign unused_stall = stall;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard scenarios plus a randomized run checked
// against an instruction-level model of the three downstream stages.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_alusrc;
  logic [1:0] id_aluop;
  logic [4:0] id_ra1, id_ra2, id_rd;
  logic       mem_zero;
  logic       ex_alusrc;
  logic [1:0] ex_aluop, forward_a, forward_b;
  logic       mem_memread, mem_memwrite, mem_branch, wb_regwrite, wb_memtoreg;
  logic [4:0] wb_rd;
  logic       pcsrc, pc_write, ifid_write, ifid_flush;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_ra1(id_ra1), .id_ra2(id_ra2), .id_rd(id_rd),
    .mem_zero(mem_zero),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .forward_a(forward_a), .forward_b(forward_b),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .pcsrc(pcsrc), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
  );

  // One instruction's decoded bundle, as seen by the model.
  typedef struct packed {
    logic rw, m2r, mr, mw, br, as;
    logic [1:0] op;
    logic [4:0] ra1, ra2, rd;
  } ins_t;

  localparam ins_t BUB = '{rw:0, m2r:0, mr:0, mw:0, br:0, as:0, op:2'b00, ra1:5'd31, ra2:5'd31, rd:5'd31};
  ins_t m_ex = BUB, m_mem = BUB, m_wb = BUB;

  function automatic ins_t mk(logic rw, logic m2r, logic mr, logic mw, logic br, logic as,
                              logic [1:0] op, logic [4:0] ra1, logic [4:0] ra2, logic [4:0] rd);
    ins_t r;
    r = '{rw:rw, m2r:m2r, mr:mr, mw:mw, br:br, as:as, op:op, ra1:ra1, ra2:ra2, rd:rd};
    return r;
  endfunction

  task automatic drive(input ins_t i);
    {id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc} =
      {i.rw, i.m2r, i.mr, i.mw, i.br, i.as};
    id_aluop = i.op; id_ra1 = i.ra1; id_ra2 = i.ra2; id_rd = i.rd;
  endtask

  function automatic ins_t cur_in();
    return mk(id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc,
              id_aluop, id_ra1, id_ra2, id_rd);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] ra);
    if (m_mem.rw && m_mem.rd != 5'd31 && m_mem.rd == ra) return 2'b10;
    if (m_wb.rw && m_wb.rd != 5'd31 && m_wb.rd == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output vector from the model and the current ID inputs.
  function automatic logic [20:0] exp_vec();
    logic br_taken, luse, hold;
    br_taken = m_mem.br && mem_zero;
    luse = m_ex.mr && m_ex.rd != 5'd31 && (m_ex.rd == id_ra1 || m_ex.rd == id_ra2);
    hold = luse && !br_taken;
    return {m_ex.as, m_ex.op, m_fwd(m_ex.ra1), m_fwd(m_ex.ra2), m_mem.mr, m_mem.mw, m_mem.br,
            m_wb.rw, m_wb.m2r, m_wb.rd, br_taken, !hold, !hold, br_taken};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {ex_alusrc, ex_aluop, forward_a, forward_b, mem_memread, mem_memwrite, mem_branch,
            wb_regwrite, wb_memtoreg, wb_rd, pcsrc, pc_write, ifid_write, ifid_flush};
  endfunction

  // Advance one clock; the model retires instructions by the pipeline's rules.
  task automatic tick();
    ins_t cur;
    logic br_taken, luse;
    cur = cur_in();
    br_taken = m_mem.br && mem_zero;
    luse = m_ex.mr && m_ex.rd != 5'd31 && (m_ex.rd == cur.ra1 || m_ex.rd == cur.ra2);
    @(posedge clk);
    if (reset) begin
      m_ex = BUB; m_mem = BUB; m_wb = BUB;
    end else begin
      m_wb  = m_mem;
      m_mem = br_taken ? BUB : m_ex;
      m_ex  = (br_taken || luse) ? BUB : cur;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    mem_zero = 1'b0;
    drive(BUB);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_zero = 1'b0;
    drive(mk(0,0,0,0,0,0,2'b00,5'd0,5'd0,5'd0));
    tick(); tick();
    reset = 1'b0; #1;
    n_chk++;
    if (dut_vec() !== {1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,5'd31,1'b0,1'b1,1'b1,1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", dut_vec(),
                         {1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,5'd31,1'b0,1'b1,1'b1,1'b0});
    end
  endtask

  task automatic test_forward();
    drain();
    drive(mk(1,0,0,0,0,0,2'b10,5'd1,5'd2,5'd3)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd3,5'd4,5'd7)); tick();
    drive(BUB); #1;
    n_chk++;
    if (forward_a !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_a: got %b want 10", forward_a); end
    n_chk++;
    if (forward_b !== 2'b00) begin n_fail++; $display("FAIL fwd_mem_b: got %b want 00", forward_b); end
    drain();
    drive(mk(1,0,0,0,0,0,2'b10,5'd1,5'd2,5'd3)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd10,5'd11,5'd9)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd3,5'd4,5'd7)); tick();
    drive(BUB); #1;
    n_chk++;
    if (forward_a !== 2'b01) begin n_fail++; $display("FAIL fwd_wb_a: got %b want 01", forward_a); end
  endtask

  task automatic test_load_use();
    drain();
    drive(mk(1,1,1,0,0,1,2'b00,5'd1,5'd31,5'd5)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd6,5'd5,5'd8)); #1;
    n_chk++;
    if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
      n_fail++; $display("FAIL load_use_stall: got %b want 000", {pc_write, ifid_write, ifid_flush});
    end
    tick(); #1;
    n_chk++;
    if ({ex_alusrc, ex_aluop, mem_memread, pc_write} !== 5'b00011) begin
      n_fail++; $display("FAIL load_use_bubble: got %b want 00011", {ex_alusrc, ex_aluop, mem_memread, pc_write});
    end
    tick();
    drive(BUB); #1;
    n_chk++;
    if ({forward_a, forward_b, ex_aluop} !== 6'b000110) begin
      n_fail++; $display("FAIL load_use_fwd: got %b want 000110", {forward_a, forward_b, ex_aluop});
    end
  endtask

  task automatic test_xzr_load();
    drain();
    drive(mk(1,1,1,0,0,1,2'b00,5'd1,5'd31,5'd31)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd31,5'd2,5'd8)); #1;
    n_chk++;
    if (pc_write !== 1'b1) begin n_fail++; $display("FAIL xzr_nostall: got %b want 1", pc_write); end
    tick(); drive(BUB); #1;
    n_chk++;
    if (forward_a !== 2'b00) begin n_fail++; $display("FAIL xzr_nofwd: got %b want 00", forward_a); end
  endtask

  task automatic test_branch();
    drain();
    drive(mk(0,0,0,0,1,0,2'b01,5'd31,5'd2,5'd31)); tick();
    drive(mk(1,0,0,0,0,1,2'b10,5'd1,5'd2,5'd4)); tick();
    drive(mk(1,1,1,0,0,1,2'b00,5'd1,5'd2,5'd6));
    mem_zero = 1'b1; #1;
    n_chk++;
    if ({pcsrc, ifid_flush, pc_write} !== 3'b111) begin
      n_fail++; $display("FAIL branch_taken: got %b want 111", {pcsrc, ifid_flush, pc_write});
    end
    // Control bits go X during the flush; the bubble must mask them.
    {id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc, id_aluop} = 'x;
    tick();
    mem_zero = 1'b0; drive(BUB); #1;
    n_chk++;
    if ({ex_alusrc, ex_aluop, mem_memread, mem_memwrite, mem_branch, wb_regwrite, pcsrc} !== 8'b0) begin
      n_fail++; $display("FAIL branch_flush: got %b want 00000000",
                         {ex_alusrc, ex_aluop, mem_memread, mem_memwrite, mem_branch, wb_regwrite, pcsrc});
    end
    drain();
    drive(mk(0,0,0,0,1,0,2'b01,5'd31,5'd2,5'd31)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd1,5'd2,5'd4)); tick();
    drive(mk(0,0,0,1,0,1,2'b10,5'd1,5'd2,5'd31)); #1;
    n_chk++;
    if ({pcsrc, ifid_flush} !== 2'b00) begin
      n_fail++; $display("FAIL branch_not_taken: got %b want 00", {pcsrc, ifid_flush});
    end
    tick(); drive(BUB); #1;
    n_chk++;
    if ({ex_alusrc, ex_aluop, mem_branch} !== 4'b1100) begin
      n_fail++; $display("FAIL branch_no_flush: got %b want 1100", {ex_alusrc, ex_aluop, mem_branch});
    end
  endtask

  task automatic test_flush_over_stall();
    drain();
    drive(mk(0,0,0,0,1,0,2'b01,5'd31,5'd2,5'd31)); tick();
    drive(mk(1,1,1,0,0,1,2'b00,5'd1,5'd31,5'd5)); tick();
    drive(mk(1,0,0,0,0,0,2'b10,5'd5,5'd2,5'd8));
    mem_zero = 1'b1; #1;
    n_chk++;
    if ({pcsrc, pc_write, ifid_write, ifid_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL flush_prio: got %b want 1111", {pcsrc, pc_write, ifid_write, ifid_flush});
    end
    tick();
    mem_zero = 1'b0; drive(BUB); #1;
    n_chk++;
    if ({ex_aluop, mem_memread, wb_regwrite, pc_write} !== 5'b00001) begin
      n_fail++; $display("FAIL flush_prio_after: got %b want 00001", {ex_aluop, mem_memread, wb_regwrite, pc_write});
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(mk(1,1,1,0,0,1,2'b00,5'd1,5'd31,5'd5)); tick();
    drive(mk(1,0,0,0,0,1,2'b11,5'd5,5'd2,5'd8)); #1;
    n_chk++;
    if (pc_write !== 1'b0) begin n_fail++; $display("FAIL mid_stall_pre: got %b want 0", pc_write); end
    reset = 1'b1; tick(); reset = 1'b0; #1;
    n_chk++;
    if (dut_vec() !== {1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,5'd31,1'b0,1'b1,1'b1,1'b0}) begin
      n_fail++; $display("FAIL mid_stall_reset: got %b want %b", dut_vec(),
                         {1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,5'd31,1'b0,1'b1,1'b1,1'b0});
    end
  endtask

  // Small register pool so hazards and XZR cases are frequent.
  function automatic logic [4:0] rreg();
    logic [4:0] pool [5];
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
    return pool[$urandom_range(0, 4)];
  endfunction

  task automatic test_random();
    logic [20:0] e;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      mem_zero = $urandom_range(0, 1);
      drive(mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,2) == 0,
               $urandom_range(0,3) == 0, $urandom_range(0,4) == 0, $urandom_range(0,1),
               2'($urandom_range(0,3)), rreg(), rreg(), rreg()));
      #1;
      e = exp_vec();
      n_chk++;
      if (dut_vec() !== e) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b want %b", c, dut_vec(), e);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_xzr_load();
    test_branch();
    test_flush_over_stall();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the main decoder's control bundle. Carries the decoded ID-stage control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage LEGv8 pipeline, together with the register numbers each stage needs.
- Also produces the hazard controls: load-use stall, taken-branch flush, and EX-stage forwarding selects.
- The datapath keeps its data pipeline registers; this block owns only control and register-number state.

Parameters:
- REG_W, 5, register-number width.
- XZR, 31, zero register; never matched for hazards or forwarding.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_alusrc  in  1 each  decoded control bits from the main decoder.
- id_aluop  in  2  decoded ALUOp.
- id_ra1, id_ra2  in  REG_W  register numbers actually read in ID (ra2 is already after the Reg2Loc mux).
- id_rd  in  REG_W  destination register (Rt for LDUR).
- mem_zero  in  1  ALU zero flag latched in EX/MEM (datapath).
- ex_alusrc  out  1  ID/EX control.
- ex_aluop  out  2  ID/EX control.
- forward_a, forward_b  out  2  operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- mem_memread, mem_memwrite, mem_branch  out  1  EX/MEM control.
- wb_regwrite, wb_memtoreg  out  1  MEM/WB control.
- wb_rd  out  REG_W  write-back register number.
- pcsrc  out  1  branch taken; PC loads the branch target.
- pc_write, ifid_write  out  1  0 holds the PC and IF/ID.
- ifid_flush  out  1  IF/ID loads a NOP.

Behaviour:
- Registers:
  - ID/EX holds {ctrl, ra1, ra2, rd}.
  - EX/MEM holds {ctrl, rd}.
  - MEM/WB holds {regwrite, memtoreg, rd}.
  - All registers update on posedge clk.
- Reset (synchronous): every control bit in every stage is 0, every stored rd/ra is XZR. After reset:
  - forward_a = forward_b = 00, pcsrc = 0, ifid_flush = 0.
  - pc_write = ifid_write = 1.
- Bubble: all control bits are 0 and register numbers are XZR. X on any id_* control bit is masked to 0 whenever a bubble is selected.
- pcsrc = mem_branch & mem_zero (combinational).
- Load-use stall (combinational):
  - stall = ex_memread & (ex_rd != XZR) & (ex_rd == id_ra1 | ex_rd == id_ra2).
  - Under stall: pc_write = ifid_write = 0, and ID/EX loads a bubble next edge.
  - EX/MEM and MEM/WB advance normally.
  - Latency: exactly one stall cycle per load-use pair.
- Flush on pcsrc:
  - ifid_flush = 1.
  - ID/EX and EX/MEM both load bubbles next edge.
  - pc_write = ifid_write = 1 regardless of stall; flush has priority over stall.
  - MEM/WB still captures the branch instruction's (zero) WB control.
- Normal operation: ID/EX <= id inputs, EX/MEM <= ID/EX, MEM/WB <= EX/MEM.
- Forwarding (combinational; A uses ex_ra1, B uses ex_ra2):
  - 10 if mem_regwrite & mem_rd != XZR & mem_rd == ex_raN.
  - Else 01 if wb_regwrite & wb_rd != XZR & wb_rd == ex_raN.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
  - mem_regwrite and mem_rd are internal EX/MEM fields.
- Register-file write-through in the same cycle is the datapath's concern; no ID-stage forwarding here.
- Reset asserted mid-stream: all stages become bubbles on that edge, with no pending stall or flush afterwards.

Decomposition:
- Shared package ctrl_pkg:
  - ex_ctrl_t {alusrc, aluop[1:0]}, mem_ctrl_t {memread, memwrite, branch}, wb_ctrl_t {regwrite, memtoreg}.
  - XZR constant.
  - Forward encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Bubble constants for each struct.
- One sub-module, hazard_unit (combinational): stall, flush, pc_write, ifid_write and both forwarding selects. The pipeline registers stay in ctrl_pipe.

Test Plan:
- Reset held 2 cycles, then released with all id_* = 0 -> every output is 0, wb_rd = 31, pc_write = ifid_write = 1, forward_a = forward_b = 00.
- R-type ADD with rd = 3, regwrite = 1, aluop = 10, then on the next cycle an instruction with ra1 = 3 -> in that instruction's EX cycle forward_a = 10. An unrelated instruction inserted between them gives forward_a = 01 instead.
- LDUR with rd = 5, memread = 1, followed by an instruction with ra2 = 5 -> for one cycle pc_write = ifid_write = 0, the next ex_aluop/ex_alusrc are 0 (bubble), then forward_b = 01 in the consumer's EX cycle.
- LDUR with rd = 31 followed by a reader of ra1 = 31 -> no stall, forward_a = 00.
- CBZ (branch = 1, aluop = 01) with mem_zero = 1 in its MEM cycle -> pcsrc = 1 and ifid_flush = 1 that cycle. The next cycle ex_* and mem_* control are all 0, wb_regwrite = 0. With mem_zero = 0 there is no flush.
- Load-use stall condition in the same cycle as pcsrc = 1 -> pc_write = 1 and ifid_flush = 1, no stall. Separately, reset asserted while a stall is active -> the next cycle shows the reset state.
